// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES encrypt/decrypt core.
// Runs ROUNDS_PER_CYCLE Feistel rounds per clock over a 3-state FSM.
module des_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [63:0] key,
   input  logic [63:0] din,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] dout,
   output logic        busy,
   output logic [4:0]  round_cnt
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
         ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8 ||
         ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17, 9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7
   };

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41, 9, 49, 17, 57, 25
   };

   localparam int E_T [48] = '{
      32, 1, 2, 3, 4, 5,
      4, 5, 6, 7, 8, 9,
      8, 9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32, 1
   };

   localparam int P_T [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17,
      1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9,
      19, 13, 30, 6, 22, 11, 4, 25
   };

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17, 9,
      1, 58, 50, 42, 34, 26, 18,
      10, 2, 59, 51, 43, 35, 27,
      19, 11, 3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
      7, 62, 54, 46, 38, 30, 22,
      14, 6, 61, 53, 45, 37, 29,
      21, 13, 5, 28, 20, 12, 4
   };

   localparam int PC2_T [48] = '{
      14, 17, 11, 24, 1, 5,
      3, 28, 15, 6, 21, 10,
      23, 19, 12, 4, 26, 8,
      16, 7, 27, 20, 13, 2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // S1..S8, four rows each, entry 0 in the top nibble
   localparam logic [2047:0] SB = {
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
      return y;
   endfunction

   function automatic logic [63:0] ip_inv(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
      return y;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
      return y;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
      return y;
   endfunction

   function automatic logic [47:0] expand(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int j = 0; j < 48; j++) y[47-j] = x[32-E_T[j]];
      return y;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int j = 0; j < 32; j++) y[31-j] = x[32-P_T[j]];
      return y;
   endfunction

   // row = outer bits, column = inner four bits
   function automatic logic [31:0] sbox(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0]  b;
      logic [5:0]  idx;
      y = '0;
      for (int k = 0; k < 8; k++) begin
         b   = x[47-6*k -: 6];
         idx = {b[5], b[0], b[4:1]};
         y[31-4*k -: 4] = SB[2047-256*k-4*int'(idx) -: 4];
      end
      return y;
   endfunction

   function automatic logic [31:0] feistel(
      input logic [31:0] r,
      input logic [47:0] k
   );
      return perm_p(sbox(expand(r) ^ k));
   endfunction

   function automatic int shamt(input int n);
      return (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
      return (n == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
      return (n == 1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   state_t      state;
   logic        mode_q;
   logic [31:0] l, r;
   logic [27:0] c, d;
   logic [31:0] l_nx, r_nx;
   logic [27:0] c_nx, d_nx;

   // Chain ROUNDS_PER_CYCLE rounds; decrypt walks the key schedule backwards
   always_comb begin
      logic [31:0] lt, rt, tt;
      logic [27:0] ct, dt;
      logic [47:0] kt;
      int          rn;
      lt = l;
      rt = r;
      ct = c;
      dt = d;
      tt = '0;
      kt = '0;
      rn = 0;
      for (int s = 0; s < ROUNDS_PER_CYCLE; s++) begin
         rn = int'(round_cnt) + s + 1;
         if (mode_q) begin
            ct = rotl(ct, shamt(rn));
            dt = rotl(dt, shamt(rn));
         end else if (rn != 1) begin
            ct = rotr(ct, shamt(18 - rn));
            dt = rotr(dt, shamt(18 - rn));
         end
         kt = pc2({ct, dt});
         tt = lt ^ feistel(rt, kt);
         lt = rt;
         rt = tt;
      end
      l_nx = lt;
      r_nx = rt;
      c_nx = ct;
      d_nx = dt;
   end

   // Block FSM: accept, iterate rounds, hold result until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         l         <= '0;
         r         <= '0;
         c         <= '0;
         d         <= '0;
         dout      <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         round_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mode_q    <= mode;
                  {l, r}    <= ip(din);
                  {c, d}    <= pc1(key);
                  round_cnt <= '0;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (round_cnt == 5'd16) begin
                  dout      <= ip_inv({r, l});
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  l         <= l_nx;
                  r         <= r_nx;
                  c         <= c_nx;
                  d         <= d_nx;
                  round_cnt <= round_cnt + 5'(ROUNDS_PER_CYCLE);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  round_cnt <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: known-answer checks of des_iter_core at every
// legal ROUNDS_PER_CYCLE, plus back-pressure and mid-block reset.
module tb_des_iter_core;

   localparam int NI = 5;
   localparam int RPC [NI] = '{1, 2, 4, 8, 16};

   localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEYP = 64'h123556789ABDDEF0;
   localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT   = 64'h85E813540F0AB405;

   typedef struct {
      int          g;
      logic        m;
      logic [63:0] key;
      logic [63:0] din;
      logic [63:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        iv  [NI];
   logic        md  [NI];
   logic [63:0] ky  [NI];
   logic [63:0] di  [NI];
   logic        orr [NI];
   logic        ir  [NI];
   logic        ov  [NI];
   logic [63:0] dq  [NI];
   logic        bz  [NI];
   logic [4:0]  rc  [NI];

   int tests = 0;
   int fails = 0;

   vec_t vt [12];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      des_iter_core #(.ROUNDS_PER_CYCLE(RPC[g])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .mode      (md[g]),
         .key       (ky[g]),
         .din       (di[g]),
         .out_valid (ov[g]),
         .out_ready (orr[g]),
         .dout      (dq[g]),
         .busy      (bz[g]),
         .round_cnt (rc[g])
      );
   end

   task automatic chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge after accept
   task automatic accept(
      input int          g,
      input logic        m,
      input logic [63:0] k,
      input logic [63:0] d,
      input string       nm
   );
      md[g] = m;
      ky[g] = k;
      di[g] = d;
      iv[g] = 1'b1;
      chk({nm, " in_ready"}, {63'd0, ir[g]}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      iv[g] = 1'b0;
   endtask

   // k counts edges since accept; inputs are scrambled while running
   task automatic wait_done(
      input int          g,
      input logic [63:0] exp,
      input string       nm
   );
      int k;
      int er;
      int lat;
      bit rc_ok;
      k = 0;
      rc_ok = 1'b1;
      lat = 16 / RPC[g] + 1;
      while (!ov[g] && k < 40) begin
         er = (k * RPC[g] > 16) ? 16 : k * RPC[g];
         if (int'(rc[g]) != er) rc_ok = 1'b0;
         if (ir[g] !== 1'b0) rc_ok = 1'b0;
         md[g] = 1'($urandom_range(1));
         ky[g] = {$urandom(), $urandom()};
         di[g] = {$urandom(), $urandom()};
         @(negedge clk);
         k++;
      end
      chk({nm, " latency"}, 64'(k), 64'(lat));
      chk({nm, " dout"}, dq[g], exp);
      chk({nm, " round_cnt steps"}, {63'd0, rc_ok}, 64'd1);
      chk({nm, " round_cnt done"}, {59'd0, rc[g]}, 64'd16);
   endtask

   task automatic release_out(input int g, input string nm);
      orr[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      orr[g] = 1'b0;
      chk({nm, " out_valid drop"}, {63'd0, ov[g]}, 64'd0);
      chk({nm, " in_ready back"}, {63'd0, ir[g]}, 64'd1);
      chk({nm, " round_cnt idle"}, {59'd0, rc[g]}, 64'd0);
      chk({nm, " busy idle"}, {63'd0, bz[g]}, 64'd0);
   endtask

   initial begin
      bit ok;
      int n;

      for (int g = 0; g < NI; g++) begin
         vt[2*g]   = '{g, 1'b1, KEY, PT, CT};
         vt[2*g+1] = '{g, 1'b0, KEY, CT, PT};
      end
      vt[10] = '{0, 1'b1, KEYP, PT, CT};
      vt[11] = '{4, 1'b1, KEYP, PT, CT};

      for (int g = 0; g < NI; g++) begin
         iv[g]  = 1'b0;
         md[g]  = 1'b0;
         ky[g]  = '0;
         di[g]  = '0;
         orr[g] = 1'b0;
      end

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset in_ready", {63'd0, ir[0]}, 64'd1);
      chk("reset out_valid", {63'd0, ov[0]}, 64'd0);
      chk("reset dout", dq[0], 64'd0);
      chk("reset busy", {63'd0, bz[0]}, 64'd0);
      chk("reset round_cnt", {59'd0, rc[0]}, 64'd0);
      chk("reset out_valid r16", {63'd0, ov[4]}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         accept(vt[i].g, vt[i].m, vt[i].key, vt[i].din,
                $sformatf("v%0d", i));
         wait_done(vt[i].g, vt[i].exp, $sformatf("v%0d", i));
         release_out(vt[i].g, $sformatf("v%0d", i));
      end

      accept(0, 1'b1, KEY, PT, "bp1");
      wait_done(0, CT, "bp1");
      md[0] = 1'b0;
      ky[0] = KEY;
      di[0] = CT;
      iv[0] = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (dq[0] !== CT || ov[0] !== 1'b1 || ir[0] !== 1'b0)
            ok = 1'b0;
      end
      chk("bp hold", {63'd0, ok}, 64'd1);
      orr[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      orr[0] = 1'b0;
      chk("bp ready after take", {63'd0, ir[0]}, 64'd1);
      chk("bp out_valid after take", {63'd0, ov[0]}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      chk("bp second accepted", {62'd0, bz[0], ir[0]}, 64'd2);
      wait_done(0, PT, "bp2");
      release_out(0, "bp2");

      accept(0, 1'b1, KEY, PT, "rst");
      n = 0;
      while (rc[0] != 5'd7 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rst reach round 7", {59'd0, rc[0]}, 64'd7);
      #2 rst = 1'b1;
      #1;
      chk("rst out_valid", {63'd0, ov[0]}, 64'd0);
      chk("rst in_ready", {63'd0, ir[0]}, 64'd1);
      chk("rst round_cnt", {59'd0, rc[0]}, 64'd0);
      chk("rst busy", {63'd0, bz[0]}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      accept(0, 1'b1, KEY, PT, "post");
      wait_done(0, CT, "post");
      release_out(0, "post");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
